// File: rtl/spi_flash_responder.sv
// SPI-flash target model: READ (03h) from an internal byte memory, plus DEEP POWER-DOWN (B9h)
// and RELEASE/READ-ID (ABh). SPI pins are oversampled in the CLK domain (mode 0).
module spi_flash_responder #(
  parameter int unsigned ADDR_BITS   = 12,
  parameter logic [7:0]  DEVICE_ID   = 8'h14,
  parameter int unsigned WAKE_CYCLES = 30
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 flash_sclk,
  input  logic                 flash_csb,
  input  logic                 flash_mosi,
  output logic                 flash_miso,
  input  logic                 mem_we,
  input  logic [ADDR_BITS-1:0] mem_addr,
  input  logic [7:0]           mem_wdata,
  output logic                 asleep,
  output logic                 busy,
  output logic [7:0]           last_cmd
);

  localparam int unsigned MemSize = 2 ** ADDR_BITS;
  localparam int unsigned WakeW   = $clog2(WAKE_CYCLES + 1);

  localparam logic [7:0] CmdRead  = 8'h03;
  localparam logic [7:0] CmdSleep = 8'hB9;
  localparam logic [7:0] CmdWake  = 8'hAB;

  typedef enum logic [2:0] {
    StIdle, StCmd, StAddr, StData, StDummy, StArmSleep, StIgnore
  } state_e;

  state_e state_q, state_d;

  // Third flop of SCLK/CSB holds the previous synced value for edge detection.
  logic [2:0] sclk_q;
  logic [2:0] csb_q;
  logic [1:0] mosi_q;

  logic [5:0]           bit_cnt_q;
  logic [ADDR_BITS-1:0] sr_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [4:0]           fcnt_q;
  logic [2:0]           bcnt_q;
  logic [7:0]           out_q;
  logic                 from_sleep_q;
  logic [WakeW-1:0]     wake_cnt_q;
  logic                 miso_q;
  logic                 asleep_q;
  logic [7:0]           last_cmd_q;

  logic [7:0] mem [MemSize];
  logic [7:0] mem_rd;

  logic       sclk_rise, sclk_fall, csb_rise, csb_fall, mosi_s;
  logic [7:0] cmd_byte;
  logic       awake_ready, cmd_done, addr_done;

  assign sclk_rise   = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall   = ~sclk_q[1] & sclk_q[2];
  assign csb_rise    = csb_q[1] & ~csb_q[2];
  assign csb_fall    = ~csb_q[1] & csb_q[2];
  assign mosi_s      = mosi_q[1];
  assign cmd_byte    = {sr_q[6:0], mosi_s};
  assign awake_ready = ~asleep_q & (wake_cnt_q == '0);
  assign cmd_done    = (state_q == StCmd) & sclk_rise & (bit_cnt_q == 6'd7);
  assign addr_done   = (state_q == StAddr) & sclk_rise & (bit_cnt_q == 6'd31);

  always_comb begin
    state_d = state_q;
    if (csb_rise) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: if (csb_fall) state_d = StCmd;
        StCmd: begin
          if (cmd_done) begin
            if (cmd_byte == CmdWake)                      state_d = StDummy;
            else if (awake_ready && cmd_byte == CmdRead)  state_d = StAddr;
            else if (awake_ready && cmd_byte == CmdSleep) state_d = StArmSleep;
            else                                          state_d = StIgnore;
          end
        end
        StAddr: if (addr_done) state_d = StData;
        default: ;
      endcase
    end
  end

  // Asynchronous read: a preload to the address being fetched lands after this cycle,
  // so SPI sees the pre-write byte.
  assign mem_rd = mem[addr_q];

  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= StIdle;
      sclk_q       <= '0;
      csb_q        <= '0;
      mosi_q       <= '0;
      bit_cnt_q    <= '0;
      sr_q         <= '0;
      addr_q       <= '0;
      fcnt_q       <= '0;
      bcnt_q       <= '0;
      out_q        <= '0;
      from_sleep_q <= 1'b0;
      wake_cnt_q   <= '0;
      miso_q       <= 1'b0;
      asleep_q     <= 1'b0;
      last_cmd_q   <= 8'h00;
    end else begin
      sclk_q  <= {sclk_q[1:0], flash_sclk};
      csb_q   <= {csb_q[1:0], flash_csb};
      mosi_q  <= {mosi_q[0], flash_mosi};
      state_q <= state_d;

      if (wake_cnt_q != '0) wake_cnt_q <= wake_cnt_q - 1'b1;

      if (csb_fall) begin
        bit_cnt_q <= '0;
        fcnt_q    <= '0;
        bcnt_q    <= '0;
        miso_q    <= 1'b0;
      end

      if (state_q != StIdle && sclk_rise) begin
        if (bit_cnt_q != 6'h3f) bit_cnt_q <= bit_cnt_q + 1'b1;
        sr_q <= {sr_q[ADDR_BITS-2:0], mosi_s};
      end

      if (cmd_done) begin
        last_cmd_q   <= cmd_byte;
        from_sleep_q <= asleep_q;
      end

      if (addr_done) addr_q <= {sr_q[ADDR_BITS-2:0], mosi_s};

      if (sclk_fall && state_q == StData) begin
        if (bcnt_q == 3'd0) begin
          miso_q <= mem_rd[7];
          out_q  <= {mem_rd[6:0], 1'b0};
        end else begin
          miso_q <= out_q[7];
          out_q  <= {out_q[6:0], 1'b0};
        end
        bcnt_q <= bcnt_q + 1'b1;
        if (bcnt_q == 3'd7) addr_q <= addr_q + 1'b1;
      end

      // 24 zero bits after the opcode, then the ID byte repeats (all zero if woken from sleep).
      if (sclk_fall && state_q == StDummy) begin
        if (fcnt_q != 5'd24) begin
          miso_q <= 1'b0;
          fcnt_q <= fcnt_q + 1'b1;
        end else begin
          miso_q <= ~from_sleep_q & DEVICE_ID[3'd7 - bcnt_q];
          bcnt_q <= bcnt_q + 1'b1;
        end
      end

      if (csb_rise) begin
        miso_q <= 1'b0;
        if (state_q == StArmSleep && bit_cnt_q == 6'd8) asleep_q <= 1'b1;
        if (state_q == StDummy && from_sleep_q) begin
          asleep_q   <= 1'b0;
          wake_cnt_q <= WakeW'(WAKE_CYCLES);
        end
      end
    end
  end

  assign flash_miso = miso_q;
  assign asleep     = asleep_q;
  assign busy       = (wake_cnt_q != '0);
  assign last_cmd   = last_cmd_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Randomized bench for spi_flash_responder: a transaction-level model predicts MISO bytes,
// sleep state and the busy window; a per-cycle monitor compares idle-time outputs.
module tb_spi_flash_responder;

  localparam int AW   = 12;
  localparam int MEM  = 1 << AW;
  localparam int WAKE = 120;  // long enough that a READ can be dispatched inside the window
  localparam int HALF = 4;
  localparam logic [7:0] ID = 8'h14;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sclk = 1'b0;
  logic          csb = 1'b1;
  logic          mosi = 1'b0;
  logic          miso;
  logic          mem_we = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic [7:0]    mem_wdata = '0;
  logic          asleep;
  logic          busy;
  logic [7:0]    last_cmd;

  spi_flash_responder #(
    .ADDR_BITS  (AW),
    .DEVICE_ID  (ID),
    .WAKE_CYCLES(WAKE)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .flash_sclk(sclk),
    .flash_csb (csb),
    .flash_mosi(mosi),
    .flash_miso(miso),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .asleep    (asleep),
    .busy      (busy),
    .last_cmd  (last_cmd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail = 0;

  logic [7:0] mdl_mem [MEM];
  bit         mdl_asleep = 1'b0;
  logic [7:0] mdl_last_cmd = 8'h00;
  bit         mdl_check = 1'b0;
  bit         started = 1'b0;
  int         wake_c0 = -100000;
  int         busy_hi = 0;
  bit         exp_busy;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // busy is high from 3 CLKs after CSB is raised (2 sync + 1 update) for WAKE cycles.
  always @(negedge clk) begin
    if (started && !rst) begin
      exp_busy = (cyc - wake_c0 >= 3) && (cyc - wake_c0 < 3 + WAKE);
      check("busy_window", 32'(busy), 32'(exp_busy));
      if (busy) busy_hi++;
      if (mdl_check) begin
        check("idle_asleep", 32'(asleep), 32'(mdl_asleep));
        check("idle_last_cmd", 32'(last_cmd), 32'(mdl_last_cmd));
        check("idle_miso", 32'(miso), 32'd0);
      end
    end
  end

  function automatic bit busy_at_dispatch();
    int est;
    est = cyc + 4 + 16 * HALF;
    return (est - wake_c0 >= 3) && (est - wake_c0 < 3 + WAKE);
  endfunction

  task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
    mem_we = 1'b1;
    mem_addr = a;
    mem_wdata = d;
    mdl_mem[a] = d;
    tick(1);
    mem_we = 1'b0;
  endtask

  // Mode 0: MOSI set while SCLK low, MISO sampled just before each rise.
  task automatic spi_clock_bits(input int nbits);
    logic [7:0] acc;
    logic [7:0] tb;
    int bi;
    acc = 8'h00;
    rx_q.delete();
    for (int i = 0; i < nbits; i++) begin
      bi = i / 8;
      tb = (bi < tx_q.size()) ? tx_q[bi] : 8'h00;
      tb = tb << (i % 8);
      mosi = tb[7];
      tick(HALF);
      acc = {acc[6:0], miso};
      sclk = 1'b1;
      tick(HALF);
      sclk = 1'b0;
      if (i % 8 == 7) rx_q.push_back(acc);
    end
  endtask

  task automatic run_xfer(input int nbits);
    logic [7:0]    exp_q[$];
    logic [7:0]    cmd;
    logic [7:0]    e;
    logic [AW-1:0] a;
    logic [AW-1:0] ai;
    bit            ok;
    bit            wake;
    cmd = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
    a = (tx_q.size() >= 4) ? AW'({tx_q[1], tx_q[2], tx_q[3]}) : '0;
    ok = !mdl_asleep && !busy_at_dispatch();
    for (int k = 0; k < nbits / 8; k++) begin
      e = 8'h00;
      if (cmd == 8'h03 && ok && k >= 4) begin
        ai = a + AW'(k - 4);
        e = mdl_mem[ai];
      end else if (cmd == 8'hAB && k >= 4 && !mdl_asleep) begin
        e = ID;
      end
      exp_q.push_back(e);
    end
    wake = (nbits >= 8) && (cmd == 8'hAB) && mdl_asleep;

    mdl_check = 1'b0;
    csb = 1'b0;
    tick(4);
    spi_clock_bits(nbits);
    tick(HALF);
    csb = 1'b1;
    if (wake) wake_c0 = cyc;
    tick(6);

    for (int k = 0; k < exp_q.size(); k++) begin
      check("rx_byte", 32'(rx_q[k]), 32'(exp_q[k]));
    end
    if (nbits >= 8) begin
      mdl_last_cmd = cmd;
      if (cmd == 8'hB9 && ok && nbits == 8) mdl_asleep = 1'b1;
      if (wake) mdl_asleep = 1'b0;
    end
    mdl_check = 1'b1;
    tick(3);
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected finish", cyc);
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    int op;
    int nb;
    bit w;
    logic [7:0] c;

    tick(3);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_asleep", 32'(asleep), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_last_cmd", 32'(last_cmd), 32'h00);
    rst = 1'b0;
    started = 1'b1;
    tick(2);

    for (int i = 0; i < MEM; i++) begin
      mem_we = 1'b1;
      mem_addr = AW'(i);
      mem_wdata = 8'($urandom);
      mdl_mem[AW'(i)] = mem_wdata;
      tick(1);
    end
    mem_we = 1'b0;
    mdl_check = 1'b1;
    tick(2);

    // Basic READ.
    preload(12'h010, 8'hA5);
    preload(12'h011, 8'h5A);
    preload(12'h012, 8'hC3);
    preload(12'h013, 8'h3C);
    tx_q = '{8'h03, 8'h00, 8'h00, 8'h10};
    run_xfer(64);
    check("read_b0", 32'(rx_q[4]), 32'hA5);
    check("read_b1", 32'(rx_q[5]), 32'h5A);
    check("read_b2", 32'(rx_q[6]), 32'hC3);
    check("read_b3", 32'(rx_q[7]), 32'h3C);
    check("read_last_cmd", 32'(last_cmd), 32'h03);

    // Address wrap.
    preload(12'hFFF, 8'h11);
    preload(12'h000, 8'h22);
    tx_q = '{8'h03, 8'h00, 8'h0F, 8'hFF};
    run_xfer(48);
    check("wrap_b0", 32'(rx_q[4]), 32'h11);
    check("wrap_b1", 32'(rx_q[5]), 32'h22);

    // Sleep, read while asleep, wake, read while busy, read after busy.
    tx_q = '{8'hB9};
    run_xfer(8);
    check("sleep_set", 32'(asleep), 32'd1);
    tx_q = '{8'h03, 8'h00, 8'h00, 8'h10};
    run_xfer(48);
    check("sleep_read", 32'(rx_q[4]), 32'h00);
    busy_hi = 0;
    tx_q = '{8'hAB};
    run_xfer(8);
    check("wake_asleep", 32'(asleep), 32'd0);
    check("wake_busy", 32'(busy), 32'd1);
    tx_q = '{8'h03, 8'h00, 8'h00, 8'h10};
    run_xfer(48);
    check("busy_read_b0", 32'(rx_q[4]), 32'h00);
    check("busy_read_b1", 32'(rx_q[5]), 32'h00);
    tick(WAKE);
    check("busy_length", 32'(busy_hi), 32'(WAKE));
    tx_q = '{8'h03, 8'h00, 8'h00, 8'h10};
    run_xfer(48);
    check("post_wake_b0", 32'(rx_q[4]), 32'hA5);
    check("post_wake_b1", 32'(rx_q[5]), 32'h5A);

    // B9 with an extra clock, B9 partial byte: no sleep either way.
    tx_q = '{8'hB9};
    run_xfer(9);
    check("b9_extra", 32'(asleep), 32'd0);
    tx_q = '{8'hB9};
    run_xfer(5);
    check("b9_partial", 32'(asleep), 32'd0);
    check("partial_last_cmd", 32'(last_cmd), 32'hB9);

    // Awake read-ID.
    tx_q = '{8'hAB};
    run_xfer(48);
    check("id_b1", 32'(rx_q[1]), 32'h00);
    check("id_b3", 32'(rx_q[3]), 32'h00);
    check("id_b4", 32'(rx_q[4]), 32'h14);
    check("id_b5", 32'(rx_q[5]), 32'h14);

    // Randomized mix.
    for (int it = 0; it < 50; it++) begin
      op = $urandom_range(0, 5);
      tx_q.delete();
      case (op)
        0: repeat (3) preload(AW'($urandom), 8'($urandom));
        1: begin
          tx_q = '{8'h03, 8'($urandom), 8'($urandom), 8'($urandom)};
          run_xfer(32 + 8 * int'($urandom_range(1, 4)));
        end
        2: begin
          tx_q = '{8'hB9};
          nb = ($urandom_range(0, 2) == 0) ? 8 + int'($urandom_range(1, 8)) : 8;
          run_xfer(nb);
        end
        3: begin
          w = mdl_asleep;
          tx_q = '{8'hAB};
          run_xfer(8 + 8 * int'($urandom_range(0, 5)));
          if (w) tick(WAKE + 10);
        end
        4: begin
          c = 8'($urandom);
          if (c == 8'h03 || c == 8'hAB || c == 8'hB9) c = 8'h9F;
          tx_q = '{c, 8'($urandom)};
          run_xfer(16);
        end
        default: begin
          tx_q = '{8'($urandom)};
          run_xfer(int'($urandom_range(1, 7)));
        end
      endcase
    end

    // Reset during an awake READ data phase.
    if (mdl_asleep) begin
      tx_q = '{8'hAB};
      run_xfer(8);
      tick(WAKE + 10);
    end
    preload(12'h020, 8'hFF);
    tx_q = '{8'h03, 8'h00, 8'h00, 8'h20};
    mdl_check = 1'b0;
    csb = 1'b0;
    tick(4);
    spi_clock_bits(36);
    tick(HALF);
    check("rst_pre_miso", 32'(miso), 32'd1);
    rst = 1'b1;
    wake_c0 = -100000;
    mdl_asleep = 1'b0;
    mdl_last_cmd = 8'h00;
    tick(1);
    check("rst_mid_miso", 32'(miso), 32'd0);
    check("rst_mid_last_cmd", 32'(last_cmd), 32'h00);
    rst = 1'b0;
    tick(3);
    csb = 1'b1;
    tick(6);
    mdl_check = 1'b1;
    tick(3);

    // Reset while asleep; CSB stays low across reset so a B9 clocked afterwards must be ignored.
    tx_q = '{8'hB9};
    run_xfer(8);
    check("rst_sleep_pre", 32'(asleep), 32'd1);
    tx_q = '{8'h03, 8'h00, 8'h00, 8'h10};
    mdl_check = 1'b0;
    csb = 1'b0;
    tick(4);
    spi_clock_bits(20);
    rst = 1'b1;
    mdl_asleep = 1'b0;
    mdl_last_cmd = 8'h00;
    tick(1);
    check("rst_sleep_asleep", 32'(asleep), 32'd0);
    check("rst_sleep_miso", 32'(miso), 32'd0);
    rst = 1'b0;
    tick(3);
    tx_q = '{8'hB9};
    spi_clock_bits(8);
    tick(HALF);
    csb = 1'b1;
    tick(6);
    check("rst_no_resume", 32'(asleep), 32'd0);
    mdl_check = 1'b1;
    tick(3);

    tx_q = '{8'h03, 8'h00, 8'h00, 8'h10};
    run_xfer(48);
    check("after_rst_b0", 32'(rx_q[4]), 32'hA5);
    check("after_rst_b1", 32'(rx_q[5]), 32'h5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_flash_responder.md
# spi_flash_responder

Synthesizable SPI-flash target model that answers the `flash_csb`/`flash_sclk`/`flash_mosi`/`flash_miso` pins driven by the slurm16 flash controller. It sits on the opposite side of the flash interface from the CPU's SPI master, in regression benches and FPGA loopback builds. It serves READ (03h) from an internal byte memory, and models DEEP POWER-DOWN (B9h) and RELEASE/READ-ID (ABh), so the flash sleep/wake paths can be checked end to end.

## Interface

- `ADDR_BITS`, 12: internal memory is 2^ADDR_BITS bytes; the address wraps modulo that size.
- `DEVICE_ID`, 8'h14: byte returned repeatedly after the ABh dummy bytes.
- `WAKE_CYCLES`, 30: CLK cycles of busy after a release from power-down (tRES1).
- `CLK`  in  1  system clock.
- `RST`  in  1  asynchronous, active-high reset.
- `flash_sclk`  in  1  SPI clock, mode 0, asynchronous to CLK.
- `flash_csb`  in  1  chip select, active low.
- `flash_mosi`  in  1  serial data in.
- `flash_miso`  out  1  serial data out.
- `mem_we`  in  1  bench preload write strobe.
- `mem_addr`  in  ADDR_BITS  preload address.
- `mem_wdata`  in  8  preload data.
- `asleep`  out  1  high while in deep power-down.
- `busy`  out  1  high during the wake-up window.
- `last_cmd`  out  8  last complete opcode received.

## Operation

- Input sync: `flash_sclk`, `flash_csb` and `flash_mosi` each pass through a 2-flop synchronizer; rise and fall events come from the synced SCLK.
  - Requirement: SCLK high and low phases are each ≥3 CLK cycles.
  - Requirement: CSB setup to the first SCLK rise is ≥3 CLK cycles.
- Sampling: MOSI is sampled, MSB first, on each synced SCLK rise. MISO changes only on a synced SCLK fall.
- States:
  - IDLE: CSB high, or reset. A synced CSB fall goes to CMD with the bit counter at 0.
  - CMD: shift 8 bits. On the 8th bit, latch `last_cmd` and dispatch:
    - Awake and not busy:
      - 03h → ADDR.
      - B9h → ARMSLEEP.
      - ABh → DUMMY.
      - anything else → IGNORE.
    - Asleep or busy: ABh → DUMMY; anything else → IGNORE.
  - ADDR: shift 24 bits. Address = low ADDR_BITS bits; upper bits are discarded. → DATA.
  - DATA: the output byte is `mem[addr]`, driven MSB first. After 8 falls, addr increments and wraps from 2^ADDR_BITS−1 to 0. Continues until CSB rises.
  - DUMMY: 24 clocks with MISO = 0, then DEVICE_ID repeated MSB first. If entered while asleep, it outputs 0 throughout.
  - ARMSLEEP: waits for CSB rise.
  - IGNORE: MISO = 0 until CSB rise.
- On synced CSB rise, from any state:
  - From ARMSLEEP, with exactly 8 bits clocked: set `asleep`.
  - Any ABh transaction while asleep, with ≥8 bits clocked: clear `asleep`, set `busy`, load the wake counter with WAKE_CYCLES.
  - Return to IDLE in all cases. A partial byte aborts with no effect.
- Extra clocks after B9h (bit count ≠ 8): the sleep is cancelled.
- Wake counter: decrements each CLK. `busy` drops when it reaches 0. READ during busy → IGNORE.
- Preload: on `mem_we`, `mem[mem_addr] <= mem_wdata` in the same cycle. Preload is independent of SPI activity; a same-address conflict returns the pre-write data to SPI.
- `flash_miso` is 0 whenever not actively driving data.

## Timing

- Reset values:
  - `flash_miso` = 0, `asleep` = 0, `busy` = 0, `last_cmd` = 8'h00.
  - State = IDLE; counters and shift registers = 0.
  - Memory contents are not reset.
- `RST` asserted mid-transaction aborts immediately, including clearing sleep and busy. After `RST` deasserts, the block waits for a fresh CSB fall.
- MISO latency: valid ≤4 CLK cycles after a physical SCLK fall (2 sync + 1 edge detect + 1 output register).
- First READ data bit: bit 7 of `mem[addr]` is driven on the fall following the 32nd rise (8 cmd + 24 addr).
- `last_cmd` updates 1 CLK after the synced 8th rise.
- `asleep` and `busy` update 1 CLK after the synced CSB rise.
- `busy` remains high for exactly WAKE_CYCLES CLK cycles.

## Test plan

- Preload mem[0x010..0x013] = A5,5A,C3,3C. READ 03h 00 00 10 for 32 bits → MISO returns A5 5A C3 3C; `last_cmd` = 03.
- Preload mem[0xFFF] = 11 and mem[0x000] = 22. READ at 0x000FFF for 2 bytes → 11 22 (wrap-around).
- Send B9h with a clean CSB rise → `asleep` = 1. Then READ at 0x10 → MISO stays 0. Send B9h+1 extra clock → `asleep` stays 0.
- While asleep, send ABh → `asleep` = 0 and `busy` = 1 for 30 CLKs. READ during busy → 0s. READ after busy clears → correct data.
- While awake, send ABh followed by 5 bytes of clocks → 00 00 00 14 14.
- Raise CSB after 5 bits of B9h → no sleep. Assert `RST` mid-READ → `flash_miso` = 0 and `asleep` = 0; the next READ works.
